// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a bounded memory-handshake watchdog.
// Latency 3-5 cycles plus memory waits; stalls while imem/dmem withhold ready, traps on timeout.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   output logic        imem_req,
   input  logic        imem_ready,
   output logic        ir_we,
   input  logic        dec_reg_write,
   input  logic        dec_mem_read,
   input  logic        dec_mem_write,
   input  logic        dec_illegal,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        rf_we,
   output logic        pc_we,
   output logic [2:0]  state,
   output logic [31:0] instr_cnt,
   output logic        trap
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   state_t         cur, nxt;
   logic [CW-1:0]  wait_cnt, wait_nxt;
   logic           lat_rw, lat_mr, lat_mw;
   logic           timed_out;

   assign timed_out = (wait_cnt == CW'(MEM_TIMEOUT));
   assign state     = cur;
   assign trap      = (cur == S_TRAP);

   always_comb begin
      nxt      = cur;
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      case (cur)
         S_FETCH: begin
            // once a fetch has started waiting it stays requested even if run drops
            imem_req = run | (wait_cnt != '0);
            if (imem_req) begin
               if (imem_ready) begin
                  ir_we = 1'b1;
                  nxt   = S_DECODE;
               end else if (timed_out) begin
                  nxt = S_TRAP;
               end
            end
         end
         S_DECODE: begin
            if (dec_illegal | (dec_mem_read & dec_mem_write))
               nxt = S_TRAP;
            else
               nxt = S_EXEC;
         end
         S_EXEC: begin
            if (lat_mr | lat_mw) begin
               nxt = S_MEM;
            end else if (lat_rw) begin
               nxt = S_WB;
            end else begin
               pc_we = 1'b1;
               nxt   = S_FETCH;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = lat_mw;
            if (dmem_ready) begin
               if (lat_mr) begin
                  nxt = S_WB;
               end else begin
                  pc_we = 1'b1;
                  nxt   = S_FETCH;
               end
            end else if (timed_out) begin
               nxt = S_TRAP;
            end
         end
         S_WB: begin
            rf_we = 1'b1;
            pc_we = 1'b1;
            nxt   = S_FETCH;
         end
         S_TRAP:  nxt = S_TRAP;
         default: nxt = S_TRAP;
      endcase
      // outputs follow reset immediately rather than waiting for the state flop
      if (!rst_n) begin
         imem_req = 1'b0;
         ir_we    = 1'b0;
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
         rf_we    = 1'b0;
         pc_we    = 1'b0;
      end
   end

   always_comb begin
      wait_nxt = wait_cnt;
      if ((nxt != cur) && ((nxt == S_FETCH) || (nxt == S_MEM)))
         wait_nxt = '0;
      else if (((imem_req & ~imem_ready) | (dmem_req & ~dmem_ready)) && !timed_out)
         wait_nxt = wait_cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur       <= S_FETCH;
         wait_cnt  <= '0;
         lat_rw    <= 1'b0;
         lat_mr    <= 1'b0;
         lat_mw    <= 1'b0;
         instr_cnt <= '0;
      end else begin
         cur      <= nxt;
         wait_cnt <= wait_nxt;
         if (cur == S_DECODE) begin
            lat_rw <= dec_reg_write;
            lat_mr <= dec_mem_read;
            lat_mw <= dec_mem_write;
         end
         if (pc_we)
            instr_cnt <= instr_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction outcome model feeds a scoreboard checked by a monitor.
module tb_multicycle_ctrl;

   localparam int TO = 16;
   localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_NOP = 3, K_ILL = 4, K_BOTH = 5;

   logic        clk = 1'b0;
   logic        rst_n, run, imem_ready, dmem_ready;
   logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_illegal;
   logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, trap;
   logic [2:0]  state;
   logic [31:0] instr_cnt;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
      .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
      .dec_mem_write(dec_mem_write), .dec_illegal(dec_illegal),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .rf_we(rf_we), .pc_we(pc_we), .state(state), .instr_cnt(instr_cnt), .trap(trap)
   );

   typedef struct {
      bit          is_trap;
      bit          rf;
      int          gap;
      int          dreq;
      int          dwe;
      logic [31:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] model_cnt = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic junk();
      imem_ready    = 1'($urandom);
      dmem_ready    = 1'($urandom);
      dec_reg_write = 1'($urandom);
      dec_mem_read  = 1'($urandom);
      dec_mem_write = 1'($urandom);
      dec_illegal   = 1'($urandom);
   endtask

   // One instruction: predict its outcome from the rules, queue it, then drive the handshakes.
   task automatic run_instr(input int kind, input bit rw, input int wi, input int wd, output bit trapped);
      bit   mr, mw, ill, mem, wb, will_trap;
      exp_t e;
      ill = (kind == K_ILL);
      mr  = ill ? 1'($urandom) : (kind == K_LOAD || kind == K_BOTH);
      mw  = ill ? 1'($urandom) : (kind == K_STORE || kind == K_BOTH);
      mem = mr | mw;
      wb  = mr || (!mem && rw);
      will_trap = ill || (mr && mw) || (wi > TO) || (mem && wd > TO);
      e.is_trap = will_trap;
      e.rf      = wb;
      e.gap     = 2 + (mem ? wd + 1 : 0) + (wb ? 1 : 0);
      e.dreq    = mem ? wd + 1 : 0;
      e.dwe     = mw ? wd + 1 : 0;
      e.cnt     = model_cnt;
      exp_q.push_back(e);
      if (!will_trap) model_cnt = model_cnt + 32'd1;
      trapped = 1'b1;

      for (int n = 0; n <= TO; n++) begin
         step(); junk(); run = 1'b1; imem_ready = (n == wi); #1;
         chk("fetch_state", 32'(state), 32'd0);
         chk("fetch_req", 32'(imem_req), 32'd1);
         if (n == wi) break;
         if (n == TO) begin
            step(); junk(); #1;
            chk("fetch_timeout_state", 32'(state), 32'd7);
            return;
         end
      end

      step(); junk(); run = 1'($urandom);
      dec_reg_write = rw; dec_mem_read = mr; dec_mem_write = mw; dec_illegal = ill; #1;
      chk("decode_state", 32'(state), 32'd1);
      if (ill || (mr && mw)) begin
         step(); junk(); #1;
         chk("decode_trap_state", 32'(state), 32'd7);
         return;
      end

      step(); junk(); #1;
      chk("exec_state", 32'(state), 32'd2);

      if (mem) begin
         for (int n = 0; n <= TO; n++) begin
            step(); junk(); dmem_ready = (n == wd); #1;
            chk("mem_state", 32'(state), 32'd3);
            chk("mem_req", 32'(dmem_req), 32'd1);
            chk("mem_we", 32'(dmem_we), 32'(mw));
            if (n == wd) break;
            if (n == TO) begin
               step(); junk(); #1;
               chk("mem_timeout_state", 32'(state), 32'd7);
               return;
            end
         end
      end

      if (wb) begin
         step(); junk(); #1;
         chk("wb_state", 32'(state), 32'd4);
      end
      trapped = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step(); junk(); run = 1'b0; #1;
         chk("idle_state", 32'(state), 32'd0);
         chk("idle_req", 32'(imem_req), 32'd0);
         chk("idle_ir_we", 32'(ir_we), 32'd0);
      end
   endtask

   task automatic hold_trap();
      repeat (3) begin
         step(); junk(); run = 1'b1; #1;
         chk("trap_hold_state", 32'(state), 32'd7);
         chk("trap_hold_flag", 32'(trap), 32'd1);
      end
   endtask

   task automatic do_reset(input bit keep_run);
      step();
      if (!keep_run) run = 1'b0;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_trap", 32'(trap), 32'd0);
      chk("rst_cnt", instr_cnt, 32'd0);
      chk("rst_reqs", 32'({imem_req, dmem_req}), 32'd0);
      chk("rst_strobes", 32'({ir_we, rf_we, pc_we, dmem_we}), 32'd0);
      exp_q.delete();
      model_cnt = 32'd0;
      step();
      run = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   function automatic int pick_wait();
      int r;
      r = $urandom_range(0, 39);
      if (r < 32) return $urandom_range(0, 3);
      if (r < 35) return TO;
      if (r < 38) return TO - 1;
      return TO + 1;
   endfunction

   // Monitor: pops one record per retirement or trap entry.
   initial begin
      int   gap = 0;
      int   dreq = 0;
      int   dwe = 0;
      bit   trap_prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            trap_prev = 1'b0;
            continue;
         end
         if (ir_we) begin
            gap = 0; dreq = 0; dwe = 0;
         end else begin
            gap++;
         end
         if (dmem_req) dreq++;
         if (dmem_we) dwe++;
         if (rf_we) chk("rf_we_needs_pc_we", 32'(pc_we), 32'd1);
         if (pc_we || (trap && !trap_prev)) begin
            chk("event_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("outcome_trap", 32'(trap), 32'(e.is_trap));
               chk("cnt_at_event", instr_cnt, e.cnt);
               if (pc_we) begin
                  chk("retire_rf_we", 32'(rf_we), 32'(e.rf));
                  chk("retire_latency", 32'(gap), 32'(e.gap));
                  chk("dmem_req_cycles", 32'(dreq), 32'(e.dreq));
                  chk("dmem_we_cycles", 32'(dwe), 32'(e.dwe));
               end
            end
         end
         if (trap)
            chk("trap_quiet", 32'({imem_req, dmem_req, ir_we, rf_we, pc_we, dmem_we}), 32'd0);
         trap_prev = trap;
      end
   end

   initial begin
      bit tr;
      int kind;
      bit rw;
      rst_n = 1'b0; run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
      dec_reg_write = 1'b0; dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_illegal = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("por_state", 32'(state), 32'd0);
      chk("por_trap", 32'(trap), 32'd0);
      chk("por_cnt", instr_cnt, 32'd0);
      chk("por_outputs", 32'({imem_req, dmem_req, ir_we, rf_we, pc_we, dmem_we}), 32'd0);
      run = 1'b0; imem_ready = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;

      run_instr(K_ALU, 1'b1, 0, 0, tr);
      idle(1);
      chk("add_cnt", instr_cnt, 32'd1);
      run_instr(K_LOAD, 1'b0, 0, 3, tr);
      run_instr(K_STORE, 1'b1, 0, 0, tr);
      run_instr(K_NOP, 1'b0, 0, 0, tr);
      idle(2);
      chk("directed_cnt", instr_cnt, model_cnt);
      run_instr(K_ALU, 1'b1, TO, 0, tr);
      run_instr(K_LOAD, 1'b1, 0, TO, tr);
      idle(1);
      chk("boundary_cnt", instr_cnt, model_cnt);

      run_instr(K_ALU, 1'b1, TO + 5, 0, tr);
      hold_trap();
      do_reset(1'b0);
      run_instr(K_NOP, 1'b0, 1, 0, tr);
      run_instr(K_ILL, 1'b1, 0, 0, tr);
      hold_trap();
      chk("illegal_cnt", instr_cnt, model_cnt);
      do_reset(1'b0);
      run_instr(K_STORE, 1'b0, 0, TO + 1, tr);
      hold_trap();
      do_reset(1'b0);

      repeat (3) begin
         step(); junk(); run = 1'b1; imem_ready = 1'b0; #1;
         chk("pre_reset_req", 32'(imem_req), 32'd1);
      end
      do_reset(1'b1);
      idle(2);

      step(); junk(); run = 1'b0;
      force dut.instr_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.instr_cnt;
      model_cnt = 32'hFFFF_FFFF;
      run_instr(K_NOP, 1'b0, 0, 0, tr);
      idle(1);
      chk("wrap_cnt", instr_cnt, 32'd0);

      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 31);
         kind = (r < 30) ? $urandom_range(0, 3) : ((r == 30) ? K_ILL : K_BOTH);
         rw = (kind == K_ALU) ? 1'b1 : ((kind == K_NOP) ? 1'b0 : 1'($urandom));
         run_instr(kind, rw, pick_wait(), pick_wait(), tr);
         if (tr) begin
            hold_trap();
            do_reset(1'b0);
         end else if ($urandom_range(0, 3) == 0) begin
            idle($urandom_range(1, 2));
         end
      end

      idle(3);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      chk("final_cnt", instr_cnt, model_cnt);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
